dmx_deserializer: RTL and testbench

- Serial-to-parallel receiver; the sequential counterpart of the mux-based parallel-to-serial path.
- Accepts a bit stream strobed by `inValid`: a start marker, then `WIDTH` data bits LSB first (slot `addr` = 0..WIDTH-1), then an optional parity bit.
- A demultiplexer steers each bit into its slot of a staging register; completed words go to an output register with a valid/ready handshake.
- Sits beside the MUX/DMX/CD/DC library as the receive end of the slot-addressed serial link.

---
 rtl/dmx_deserializer.sv | 110 +++++++++++
 tb/tb_dmx_deserializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmx_deserializer.sv
// Slot-addressed serial-to-parallel receiver with a valid/ready output register.
// Define DMX_PARITY_CHECK_EN to add an even-parity bit after the data bits.
module dmx_deserializer #(
  parameter int WIDTH = 8,
  localparam int ADDR_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inData,
  input  logic              inValid,
  output logic [WIDTH-1:0]  outData,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              overrun,
  output logic              frameErr
);

`ifdef DMX_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} stateT;
`else
  typedef enum logic [1:0] {IDLE, DATA, DONE} stateT;
`endif

  stateT state, nextState;
  logic [WIDTH-1:0] staging;
  logic startSeen;
  logic writeBit;
  logic lastBit;
  logic loadWord;
  logic dropWord;
`ifdef DMX_PARITY_CHECK_EN
  logic parityBad;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (startSeen) nextState = DATA;
`ifdef DMX_PARITY_CHECK_EN
      DATA:   if (lastBit) nextState = PARITY;
      PARITY: if (inValid) nextState = parityBad ? IDLE : DONE;
`else
      DATA:   if (lastBit) nextState = DONE;
`endif
      DONE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // DONE may load even when the register is full, provided the consumer drains it this cycle.
  always_comb begin
    busy      = (state != IDLE);
    startSeen = (state == IDLE) && inValid && inData;
    writeBit  = (state == DATA) && inValid;
    lastBit   = writeBit && (addr == ADDR_W'(WIDTH - 1));
    loadWord  = (state == DONE) && (!outValid || outReady);
    dropWord  = (state == DONE) && outValid && !outReady;
`ifdef DMX_PARITY_CHECK_EN
    parityBad = (state == PARITY) && inValid && (inData != ^staging);
`endif
  end

  // addr wraps to zero on the final data write because WIDTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= '0;
      staging  <= '0;
      outData  <= '0;
      outValid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= dropWord;
      if (startSeen) begin
        addr <= '0;
      end else if (writeBit) begin
        staging[addr] <= inData;
        addr          <= addr + 1'b1;
      end
      if (loadWord) begin
        outData  <= staging;
        outValid <= 1'b1;
      end else if (outReady) begin
        outValid <= 1'b0;
      end
    end
  end

`ifdef DMX_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frameErr <= 1'b0;
    end else begin
      frameErr <= parityBad;
    end
  end
`else
  assign frameErr = 1'b0;
`endif

endmodule

// File: tb/tb_dmx_deserializer.sv
// Randomized bench for dmx_deserializer; a word-level model predicts the output register and pulses.
module tb_dmx_deserializer;
  localparam int WIDTH = 8;
  localparam int AW = $clog2(WIDTH);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inData = 1'b0;
  logic inValid = 1'b0;
  logic outReady = 1'b0;
  logic [WIDTH-1:0] outData;
  logic outValid;
  logic [AW-1:0] addr;
  logic busy;
  logic overrun;
  logic frameErr;

  always #5 clk = ~clk;

  dmx_deserializer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .inData(inData),
    .inValid(inValid),
    .outData(outData),
    .outValid(outValid),
    .outReady(outReady),
    .addr(addr),
    .busy(busy),
    .overrun(overrun),
    .frameErr(frameErr)
  );

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] mData;
  logic mValid;
  logic expOv;
  logic expFe;
  logic expBusy;
  logic [AW-1:0] expAddr;
  int readyMode;
  bit forceReadyDone;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic pickReady();
    if (readyMode == 0) return 1'b0;
    if (readyMode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic checkAll();
    checkOutput("outValid", 32'(outValid), 32'(mValid));
    checkOutput("outData", 32'(outData), 32'(mData));
    checkOutput("overrun", 32'(overrun), 32'(expOv));
    checkOutput("frameErr", 32'(frameErr), 32'(expFe));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("addr", 32'(addr), 32'(expAddr));
  endtask

  // One clock of stimulus; doneEv marks the cycle a completed word is offered to the output register.
  task automatic applyStimulus(input logic v, input logic d, input logic r,
                               input bit doneEv, input logic [WIDTH-1:0] word, input bit parErr);
    inValid  = v;
    inData   = d;
    outReady = r;
    @(posedge clk);
    expOv = 1'b0;
    if (doneEv) begin
      if (!mValid || r) begin
        mData  = word;
        mValid = 1'b1;
      end else begin
        expOv = 1'b1;
      end
    end else if (r) begin
      mValid = 1'b0;
    end
    expFe = parErr;
    #1;
    checkAll();
  endtask

  task automatic doReset();
    reset    = 1'b1;
    inValid  = 1'($urandom_range(0, 1));
    inData   = 1'($urandom_range(0, 1));
    outReady = 1'b0;
    @(posedge clk);
    mData   = '0;
    mValid  = 1'b0;
    expOv   = 1'b0;
    expFe   = 1'b0;
    expBusy = 1'b0;
    expAddr = '0;
    #1;
    reset   = 1'b0;
    inValid = 1'b0;
    checkAll();
  endtask

  task automatic idleCycles(input int n, input bit filler);
    for (int i = 0; i < n; i++) begin
      expBusy = 1'b0;
      expAddr = '0;
      applyStimulus(filler ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, pickReady(), 1'b0, '0, 1'b0);
    end
  endtask

  task automatic gapCycles(input int minGap, input int maxGap);
    int n;
    n = $urandom_range(minGap, maxGap);
    for (int g = 0; g < n; g++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), pickReady(), 1'b0, '0, 1'b0);
  endtask

  // parityMode: 0 correct parity, 1 wrong parity, 2 random (ignored without the parity build).
  task automatic sendFrame(input logic [WIDTH-1:0] word, input int minGap, input int maxGap,
                           input int parityMode);
    bit bad;
    logic r;
    bad = 1'b0;
    expBusy = 1'b1;
    expAddr = '0;
    applyStimulus(1'b1, 1'b1, pickReady(), 1'b0, '0, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      expAddr = AW'(i);
      gapCycles(minGap, maxGap);
      expAddr = AW'((i + 1) % WIDTH);
      applyStimulus(1'b1, word[i], pickReady(), 1'b0, '0, 1'b0);
    end
`ifdef DMX_PARITY_CHECK_EN
    gapCycles(minGap, maxGap);
    bad = (parityMode == 2) ? ($urandom_range(0, 3) == 0) : (parityMode == 1);
    expBusy = !bad;
    expAddr = '0;
    applyStimulus(1'b1, (^word) ^ bad, pickReady(), 1'b0, '0, bad);
`endif
    if (!bad) begin
      expBusy = 1'b0;
      expAddr = '0;
      r = forceReadyDone ? 1'b1 : pickReady();
      applyStimulus(1'b0, 1'b0, r, 1'b1, word, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    readyMode = 1;
    forceReadyDone = 1'b0;
    doReset();

    sendFrame(8'hA5, 0, 0, 0);
    idleCycles(2, 1'b0);

    sendFrame(8'h3C, 3, 3, 0);
    idleCycles(2, 1'b0);

    readyMode = 0;
    sendFrame(8'h11, 0, 0, 0);
    sendFrame(8'h22, 0, 0, 0);
    checkOutput("heldAfterOverrun", 32'(outData), 32'h11);
    forceReadyDone = 1'b1;
    sendFrame(8'h33, 0, 0, 0);
    forceReadyDone = 1'b0;
    checkOutput("swapWord", 32'(outData), 32'h33);
    checkOutput("swapValid", 32'(outValid), 32'h1);

    idleCycles(3, 1'b1);
    expBusy = 1'b1;
    expAddr = '0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      expAddr = AW'(i + 1);
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b0);
    end
    doReset();
    readyMode = 1;
    sendFrame(8'hFF, 0, 0, 0);
    idleCycles(1, 1'b0);

`ifdef DMX_PARITY_CHECK_EN
    sendFrame(8'h0F, 0, 0, 0);
    idleCycles(1, 1'b0);
    sendFrame(8'h0F, 0, 0, 1);
    idleCycles(2, 1'b0);
`endif

    readyMode = 0;
    idleCycles(20, 1'b1);

    readyMode = 2;
    for (int f = 0; f < 40; f++) begin
      sendFrame(WIDTH'($urandom), 0, 2, 2);
      idleCycles($urandom_range(0, 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
